mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
Byte-serial memory controller directly downstream of the load/store buffer. It arbitrates between instruction fetch and the load/store buffer for the single 8-bit RAM port. Each 1/2/4-byte access is split into pipelined byte transactions. Loads return zero-extended, little-endian data; stores return a completion pulse.

Parameters:
ADDR_W, 32, address width
IO_MASK, 2'b11, value of addr[17:16] that selects IO space

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
rdy  in  1  global ready; low freezes all state
clear  in  1  misprediction flush
io_buffer_full  in  1  IO output buffer full
LSB_enable  in  1  LSB request, held until LSB_data_valid
LSB_is_write  in  1  1 = store, 0 = load
LSB_addr  in  32  byte address
LSB_data_len  in  3  1, 2 or 4 bytes
LSB_write_data  in  32  store data, low bytes used
LSB_data_valid  out  1  one-cycle done pulse
LSB_data  out  32  load result, zero-extended
IF_enable  in  1  fetch request, held until IF_data_valid
IF_addr  in  32  instruction address
IF_data_valid  out  1  one-cycle done pulse
IF_data  out  32  instruction word
mem_din  in  8  RAM read byte
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM address
mem_wr  out  1  1 = write

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; counters 0; internal buffer 0.
- rdy=0: every register holds its value, including outputs. The RAM is paused together with this block.
- States: IDLE, IF_RD, LSB_RD, LSB_WR.
- Accepting a request:
  - In IDLE, a request is accepted on edge T0.
  - LSB_enable has priority over IF_enable.
  - The request fields are latched at T0; requesters must keep them stable until their done pulse.
- RAM timing: mem_a driven at edge k gives mem_din that is sampled at edge k+2.
- Read of n bytes (IF fixes n=4):
  - Byte i is issued (mem_a=addr+i, mem_wr=0) at edge T0+i, for i<n.
  - Byte i is captured into buffer bits [8i+7:8i] at edge T0+i+2.
  - At edge T0+n+1: the last byte is merged, the result is driven on IF_data/LSB_data, the matching data_valid=1, and state returns to IDLE.
  - The next acceptance is at T0+n+2 at the earliest. A 4-byte read therefore has 5 edges of latency, accept to pulse.
- Write of n bytes:
  - Byte i is issued at edge T0+i with mem_a=addr+i, mem_dout=write_data[8i+7:8i], mem_wr=1.
  - At edge T0+n: mem_wr=0, LSB_data_valid=1, state returns to IDLE.
- IO stall:
  - Applies in LSB_WR when addr[17:16]==IO_MASK and io_buffer_full=1.
  - No byte is issued, mem_wr=0, and the byte counter holds. Issuing resumes the edge after io_buffer_full falls.
- data_valid pulses are exactly one cycle. data outputs hold their value until the next completion.
- Illegal LSB_data_len (0, 3, 5-7):
  - No RAM access.
  - LSB_data_valid pulses at T0+1 with LSB_data=0.
- clear=1 at an edge:
  - IF_RD and LSB_RD abort to IDLE; mem_wr=0; no done pulse.
  - LSB_WR is not aborted; the committed store completes normally.
  - In IDLE, no request is accepted on that edge.
- Address arithmetic wraps modulo 2^32.
- mem_a holds its last value while IDLE. mem_wr is 0 whenever the state is not LSB_WR.
- Reset during any operation: immediate return to IDLE, outputs 0, transaction discarded.

Test Plan:
- IF_enable, IF_addr=0x100, RAM bytes 13,05,00,00 → mem_a steps 0x100..0x103 at T0..T3; IF_data_valid at T5 with IF_data=0x00000513.
- LSB load, len=2, addr=0x1FFE, bytes 0xAB,0xCD → LSB_data=0x0000CDAB valid at T3; no byte beyond 0x1FFF is read.
- LSB_enable and IF_enable raised together → LSB served first (SW of 0xDEADBEEF to 0x20 writes EF,BE,AD,DE); IF accepted the edge after LSB_data_valid.
- SB to 0x30000 with io_buffer_full=1 for 3 cycles → mem_wr stays 0 for 3 cycles, then writes the byte; done pulse one edge later.
- clear at T2 of an IF read → no IF_data_valid, IDLE next edge. clear during a 4-byte SW → all 4 writes occur and LSB_data_valid fires.
- rst low mid LSB read, and rdy low for 2 cycles mid-read → reset: outputs 0 and IDLE immediately. rdy low: latency stretches by exactly 2 cycles and the data is correct.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller sitting between the load/store
// buffer (LSB), instruction fetch (IF) and a single 8-bit RAM port.
// Every 1/2/4-byte access becomes a train of pipelined byte transactions.
// The RAM returns the byte addressed at edge k in time for edge k+2.
//
// Ports:
//   clk, rst (async, active-low), rdy (low freezes everything), clear (flush)
//   io_buffer_full       : stalls stores into IO space (addr[17:16]==IO_MASK)
//   LSB_*                : load/store request, done pulse, zero-extended load data
//   IF_*                 : 4-byte fetch request, done pulse, instruction word
//   mem_din/dout/a/wr    : 8-bit RAM port
//   dbg_state            : current FSM state (IDLE=0, IF_RD=1, LSB_RD=2, LSB_WR=3)
//
// Handshake: a requester raises *_enable with stable fields and keeps it
// high until the matching *_data_valid pulse; it must drop the request in the
// cycle the pulse is seen. The controller accepts only from IDLE and LSB wins
// over IF when both are pending.
module mem_ctrl #(
   parameter int         ADDR_W  = 32,
   parameter logic [1:0] IO_MASK = 2'b11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              clear,
   input  logic              io_buffer_full,
   input  logic              LSB_enable,
   input  logic              LSB_is_write,
   input  logic [ADDR_W-1:0] LSB_addr,
   input  logic [2:0]        LSB_data_len,
   input  logic [31:0]       LSB_write_data,
   output logic              LSB_data_valid,
   output logic [31:0]       LSB_data,
   input  logic              IF_enable,
   input  logic [ADDR_W-1:0] IF_addr,
   output logic              IF_data_valid,
   output logic [31:0]       IF_data,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IF_RD  = 2'd1,
      LSB_RD = 2'd2,
      LSB_WR = 2'd3
   } state_t;

   state_t            state_q, state_d;
   // Reads: edges elapsed since acceptance. Writes: bytes already issued.
   logic [2:0]        cnt_q, cnt_d;
   // Byte count of the active access; 0 marks an illegal-length request.
   logic [2:0]        len_q, len_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       buf_q, buf_d;
   logic [ADDR_W-1:0] mem_a_q, mem_a_d;
   logic [7:0]        mem_dout_q, mem_dout_d;
   logic              mem_wr_q, mem_wr_d;
   logic              lsb_valid_q, lsb_valid_d;
   logic [31:0]       lsb_data_q, lsb_data_d;
   logic              if_valid_q, if_valid_d;
   logic [31:0]       if_data_q, if_data_d;

   logic              len_ok;
   logic              req_io_stall;
   logic              cur_io_stall;
   logic [ADDR_W-1:0] addr_off;
   logic [2:0]        cnt_m2;
   logic [7:0]        wr_byte;
   logic [31:0]       buf_merged;

   assign len_ok       = (LSB_data_len == 3'd1) || (LSB_data_len == 3'd2) ||
                         (LSB_data_len == 3'd4);
   assign req_io_stall = (LSB_addr[17:16] == IO_MASK) && io_buffer_full;
   assign cur_io_stall = (addr_q[17:16] == IO_MASK) && io_buffer_full;
   assign addr_off     = addr_q + ADDR_W'(cnt_q);
   // The byte arriving now was issued two edges ago.
   assign cnt_m2       = cnt_q - 3'd2;
   assign wr_byte      = wdata_q[{cnt_q[1:0], 3'b000} +: 8];

   always_comb begin
      buf_merged = buf_q;
      buf_merged[{cnt_m2[1:0], 3'b000} +: 8] = mem_din;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      buf_d       = buf_q;
      mem_a_d     = mem_a_q;
      mem_dout_d  = mem_dout_q;
      mem_wr_d    = mem_wr_q;
      lsb_valid_d = lsb_valid_q;
      lsb_data_d  = lsb_data_q;
      if_valid_d  = if_valid_q;
      if_data_d   = if_data_q;

      if (rdy) begin
         lsb_valid_d = 1'b0;
         if_valid_d  = 1'b0;
         mem_wr_d    = 1'b0;
         case (state_q)
            IDLE: begin
               if (!clear) begin
                  if (LSB_enable) begin
                     addr_d  = LSB_addr;
                     wdata_d = LSB_write_data;
                     buf_d   = '0;
                     cnt_d   = 3'd1;
                     if (!len_ok) begin
                        // Completes one edge later with zero data, no RAM access.
                        len_d   = 3'd0;
                        state_d = LSB_RD;
                     end else if (LSB_is_write) begin
                        len_d   = LSB_data_len;
                        state_d = LSB_WR;
                        if (req_io_stall) begin
                           cnt_d = 3'd0;
                        end else begin
                           mem_a_d    = LSB_addr;
                           mem_dout_d = LSB_write_data[7:0];
                           mem_wr_d   = 1'b1;
                        end
                     end else begin
                        len_d   = LSB_data_len;
                        state_d = LSB_RD;
                        mem_a_d = LSB_addr;
                     end
                  end else if (IF_enable) begin
                     addr_d  = IF_addr;
                     buf_d   = '0;
                     cnt_d   = 3'd1;
                     len_d   = 3'd4;
                     state_d = IF_RD;
                     mem_a_d = IF_addr;
                  end
               end
            end
            IF_RD, LSB_RD: begin
               if (clear) begin
                  state_d = IDLE;
                  cnt_d   = 3'd0;
               end else begin
                  if (cnt_q < len_q) mem_a_d = addr_off;
                  if (cnt_q >= 3'd2) buf_d = buf_merged;
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == len_q + 3'd1) begin
                     state_d = IDLE;
                     cnt_d   = 3'd0;
                     if (state_q == IF_RD) begin
                        if_valid_d = 1'b1;
                        if_data_d  = buf_d;
                     end else begin
                        lsb_valid_d = 1'b1;
                        lsb_data_d  = buf_d;
                     end
                  end
               end
            end
            LSB_WR: begin
               // Committed stores ignore clear and always run to completion.
               if (cnt_q < len_q) begin
                  if (!cur_io_stall) begin
                     mem_a_d    = addr_off;
                     mem_dout_d = wr_byte;
                     mem_wr_d   = 1'b1;
                     cnt_d      = cnt_q + 3'd1;
                  end
               end else begin
                  lsb_valid_d = 1'b1;
                  state_d     = IDLE;
                  cnt_d       = 3'd0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         len_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         buf_q       <= '0;
         mem_a_q     <= '0;
         mem_dout_q  <= '0;
         mem_wr_q    <= 1'b0;
         lsb_valid_q <= 1'b0;
         lsb_data_q  <= '0;
         if_valid_q  <= 1'b0;
         if_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         buf_q       <= buf_d;
         mem_a_q     <= mem_a_d;
         mem_dout_q  <= mem_dout_d;
         mem_wr_q    <= mem_wr_d;
         lsb_valid_q <= lsb_valid_d;
         lsb_data_q  <= lsb_data_d;
         if_valid_q  <= if_valid_d;
         if_data_q   <= if_data_d;
      end
   end

   assign LSB_data_valid = lsb_valid_q;
   assign LSB_data       = lsb_data_q;
   assign IF_data_valid  = if_valid_q;
   assign IF_data        = if_data_q;
   assign mem_a          = mem_a_q;
   assign mem_dout       = mem_dout_q;
   assign mem_wr         = mem_wr_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a 2-edge-latency byte RAM model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_ctrl;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_IF   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd3;

   logic        clk = 1'b0;
   logic        rst, rdy, clear, io_buffer_full;
   logic        LSB_enable, LSB_is_write;
   logic [31:0] LSB_addr;
   logic [2:0]  LSB_data_len;
   logic [31:0] LSB_write_data;
   logic        LSB_data_valid;
   logic [31:0] LSB_data;
   logic        IF_enable;
   logic [31:0] IF_addr;
   logic        IF_data_valid;
   logic [31:0] IF_data;
   logic [7:0]  mem_din = 8'h00;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [1:0]  dbg_state;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   mem_ctrl #(.ADDR_W(32), .IO_MASK(2'b11)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .io_buffer_full(io_buffer_full),
      .LSB_enable(LSB_enable), .LSB_is_write(LSB_is_write),
      .LSB_addr(LSB_addr), .LSB_data_len(LSB_data_len),
      .LSB_write_data(LSB_write_data), .LSB_data_valid(LSB_data_valid),
      .LSB_data(LSB_data), .IF_enable(IF_enable), .IF_addr(IF_addr),
      .IF_data_valid(IF_data_valid), .IF_data(IF_data),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .dbg_state(dbg_state)
   );

   // ---------------- RAM model ----------------
   logic [7:0]  ram [int unsigned];
   logic [39:0] wr_q[$];
   logic [39:0] exp_q[$];
   logic        track_rd = 1'b0;
   logic [31:0] max_rd_a = '0;

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      case (a)
         32'h100:  return 8'h13;
         32'h101:  return 8'h05;
         32'h102:  return 8'h00;
         32'h103:  return 8'h00;
         32'h1FFE: return 8'hAB;
         32'h1FFF: return 8'hCD;
         default:  return a[7:0] ^ 8'h5A;
      endcase
   endfunction

   function automatic logic [7:0] rd_ram(input logic [31:0] a);
      if (ram.exists(a)) return ram[a];
      return init_byte(a);
   endfunction

   always @(posedge clk) begin
      if (rdy) begin
         if (mem_wr) begin
            ram[mem_a] = mem_dout;
            wr_q.push_back({mem_a, mem_dout});
         end
         mem_din <= rd_ram(mem_a);
         if (track_rd && !mem_wr && mem_a > max_rd_a) max_rd_a = mem_a;
      end
   end

   // ---------------- driver helpers ----------------
   task automatic wait_valid(input bit is_if, output int n);
      n = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (is_if ? IF_data_valid : LSB_data_valid) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic lsb_req(input bit wr, input logic [31:0] a, input logic [2:0] len,
                          input logic [31:0] wd);
      LSB_enable     = 1'b1;
      LSB_is_write   = wr;
      LSB_addr       = a;
      LSB_data_len   = len;
      LSB_write_data = wd;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1;
      tests_run++;
      if ({dbg_state, mem_wr, LSB_data_valid, IF_data_valid} !== 5'b0 ||
          mem_a !== 32'h0 || LSB_data !== 32'h0 || IF_data !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_state: state=%0d wr=%b lv=%b iv=%b a=%h ld=%h id=%h, want all 0",
                  dbg_state, mem_wr, LSB_data_valid, IF_data_valid, mem_a, LSB_data, IF_data);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_if_read();
      IF_enable = 1'b1;
      IF_addr   = 32'h100;
      @(negedge clk);
      tests_run++;
      if ({dbg_state, mem_a} !== {S_IF, 32'h100}) begin
         tests_failed++;
         $display("FAIL if_issue0: state=%0d a=%h, want 1 00000100", dbg_state, mem_a);
      end
      repeat (3) @(negedge clk);
      tests_run++;
      if (mem_a !== 32'h103) begin
         tests_failed++;
         $display("FAIL if_issue3: a=%h, want 00000103", mem_a);
      end
      @(negedge clk);
      tests_run++;
      if (IF_data_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL if_early_valid: got %b, want 0", IF_data_valid);
      end
      @(negedge clk);
      tests_run++;
      if (IF_data_valid !== 1'b1 || IF_data !== 32'h00000513) begin
         tests_failed++;
         $display("FAIL if_done: valid=%b data=%h, want 1 00000513", IF_data_valid, IF_data);
      end
      IF_enable = 1'b0;
      @(negedge clk);
      tests_run++;
      if (IF_data_valid !== 1'b0 || IF_data !== 32'h00000513 || dbg_state !== S_IDLE) begin
         tests_failed++;
         $display("FAIL if_pulse_hold: valid=%b data=%h state=%0d, want 0 00000513 0",
                  IF_data_valid, IF_data, dbg_state);
      end
   endtask

   task automatic test_lsb_load();
      int n;
      max_rd_a = '0;
      track_rd = 1'b1;
      lsb_req(1'b0, 32'h1FFE, 3'd2, 32'h0);
      wait_valid(1'b0, n);
      LSB_enable = 1'b0;
      track_rd   = 1'b0;
      tests_run++;
      if (n !== 4 || LSB_data !== 32'h0000CDAB) begin
         tests_failed++;
         $display("FAIL lh_load: lat=%0d data=%h, want 3 0000cdab", n - 1, LSB_data);
      end
      tests_run++;
      if (max_rd_a !== 32'h1FFF) begin
         tests_failed++;
         $display("FAIL lh_overread: max addr %h, want 00001fff", max_rd_a);
      end
   endtask

   task automatic test_illegal_len();
      int n;
      logic [31:0] prev_a;
      prev_a = mem_a;
      wr_q.delete();
      lsb_req(1'b0, 32'h500, 3'd3, 32'h0);
      wait_valid(1'b0, n);
      LSB_enable = 1'b0;
      tests_run++;
      if (n !== 2 || LSB_data !== 32'h0 || mem_a !== prev_a || wr_q.size() != 0) begin
         tests_failed++;
         $display("FAIL bad_len: lat=%0d data=%h a=%h writes=%0d, want 1 0 %h 0",
                  n - 1, LSB_data, mem_a, wr_q.size(), prev_a);
      end
   endtask

   task automatic test_wrap();
      int n;
      lsb_req(1'b0, 32'hFFFF_FFFF, 3'd2, 32'h0);
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (mem_a !== 32'h0) begin
         tests_failed++;
         $display("FAIL wrap_addr: a=%h, want 00000000", mem_a);
      end
      wait_valid(1'b0, n);
      LSB_enable = 1'b0;
      tests_run++;
      if (n !== 2 || LSB_data !== 32'h00005AA5) begin
         tests_failed++;
         $display("FAIL wrap_data: wait=%0d data=%h, want 2 00005aa5", n, LSB_data);
      end
   endtask

   task automatic test_priority();
      int n;
      int bad;
      wr_q.delete();
      exp_q.delete();
      exp_q.push_back({32'h20, 8'hEF});
      exp_q.push_back({32'h21, 8'hBE});
      exp_q.push_back({32'h22, 8'hAD});
      exp_q.push_back({32'h23, 8'hDE});
      lsb_req(1'b1, 32'h20, 3'd4, 32'hDEADBEEF);
      IF_enable = 1'b1;
      IF_addr   = 32'h100;
      @(negedge clk);
      tests_run++;
      if ({dbg_state, mem_wr, mem_dout} !== {S_WR, 1'b1, 8'hEF} || mem_a !== 32'h20) begin
         tests_failed++;
         $display("FAIL prio_lsb_first: state=%0d wr=%b dout=%h a=%h, want 3 1 ef 00000020",
                  dbg_state, mem_wr, mem_dout, mem_a);
      end
      wait_valid(1'b0, n);
      LSB_enable = 1'b0;
      tests_run++;
      if (n !== 4) begin
         tests_failed++;
         $display("FAIL sw_latency: lat=%0d, want 4", n);
      end
      @(negedge clk);
      tests_run++;
      if (dbg_state !== S_IF || mem_a !== 32'h100) begin
         tests_failed++;
         $display("FAIL prio_if_next: state=%0d a=%h, want 1 00000100", dbg_state, mem_a);
      end
      bad = (wr_q.size() != exp_q.size()) ? 1 : 0;
      if (bad == 0) begin
         for (int i = 0; i < exp_q.size(); i++) if (wr_q[i] !== exp_q[i]) bad = 1;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL sw_bytes: %0d writes, first %h, want 4 writes ef,be,ad,de to 0x20..",
                  wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 40'h0);
      end
      wait_valid(1'b1, n);
      IF_enable = 1'b0;
      tests_run++;
      if (n !== 5 || IF_data !== 32'h00000513) begin
         tests_failed++;
         $display("FAIL prio_if_done: lat=%0d data=%h, want 5 00000513", n, IF_data);
      end
   endtask

   task automatic test_io_stall();
      int wr_seen;
      wr_seen = 0;
      wr_q.delete();
      io_buffer_full = 1'b1;
      lsb_req(1'b1, 32'h30000, 3'd1, 32'h0000005A);
      repeat (3) begin
         @(negedge clk);
         if (mem_wr || LSB_data_valid) wr_seen++;
      end
      io_buffer_full = 1'b0;
      tests_run++;
      if (wr_seen != 0) begin
         tests_failed++;
         $display("FAIL io_stall: %0d active cycles during stall, want 0", wr_seen);
      end
      @(negedge clk);
      tests_run++;
      if (mem_wr !== 1'b1 || mem_a !== 32'h30000 || mem_dout !== 8'h5A) begin
         tests_failed++;
         $display("FAIL io_resume: wr=%b a=%h dout=%h, want 1 00030000 5a", mem_wr, mem_a, mem_dout);
      end
      @(negedge clk);
      LSB_enable = 1'b0;
      tests_run++;
      if (LSB_data_valid !== 1'b1 || mem_wr !== 1'b0 || wr_q.size() != 1) begin
         tests_failed++;
         $display("FAIL io_done: valid=%b wr=%b writes=%0d, want 1 0 1",
                  LSB_data_valid, mem_wr, wr_q.size());
      end
   endtask

   task automatic test_clear_if();
      int got;
      got = 0;
      IF_enable = 1'b1;
      IF_addr   = 32'h100;
      @(negedge clk);
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear     = 1'b0;
      IF_enable = 1'b0;
      tests_run++;
      if (dbg_state !== S_IDLE || IF_data_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL clear_if_abort: state=%0d valid=%b, want 0 0", dbg_state, IF_data_valid);
      end
      repeat (6) begin
         @(negedge clk);
         if (IF_data_valid) got++;
      end
      tests_run++;
      if (got != 0) begin
         tests_failed++;
         $display("FAIL clear_if_pulse: %0d pulses, want 0", got);
      end
   endtask

   task automatic test_clear_sw();
      int n;
      lsb_req(1'b1, 32'h40, 3'd4, 32'h11223344);
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      @(negedge clk);
      clear = 1'b0;
      wait_valid(1'b0, n);
      LSB_enable = 1'b0;
      @(negedge clk);
      tests_run++;
      if (n !== 2 || {rd_ram(32'h43), rd_ram(32'h42), rd_ram(32'h41), rd_ram(32'h40)} !== 32'h11223344) begin
         tests_failed++;
         $display("FAIL clear_sw: wait=%0d mem=%h, want 2 11223344", n,
                  {rd_ram(32'h43), rd_ram(32'h42), rd_ram(32'h41), rd_ram(32'h40)});
      end
   endtask

   task automatic test_rdy_stall();
      int n;
      IF_enable = 1'b1;
      IF_addr   = 32'h200;
      @(negedge clk);
      @(negedge clk);
      rdy = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if (mem_a !== 32'h201 || dbg_state !== S_IF) begin
         tests_failed++;
         $display("FAIL rdy_freeze: a=%h state=%0d, want 00000201 1", mem_a, dbg_state);
      end
      rdy = 1'b1;
      wait_valid(1'b1, n);
      IF_enable = 1'b0;
      tests_run++;
      if (n !== 4 || IF_data !== 32'h59585B5A) begin
         tests_failed++;
         $display("FAIL rdy_stretch: lat=%0d data=%h, want 7 59585b5a", n + 3, IF_data);
      end
   endtask

   task automatic test_reset_mid();
      lsb_req(1'b0, 32'h1000, 3'd4, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++;
      if ({dbg_state, mem_wr, LSB_data_valid, IF_data_valid} !== 5'b0 ||
          mem_a !== 32'h0 || LSB_data !== 32'h0 || IF_data !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_mid: state=%0d a=%h ld=%h id=%h, want all 0",
                  dbg_state, mem_a, LSB_data, IF_data);
      end
      LSB_enable = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      rst            = 1'b0;
      rdy            = 1'b1;
      clear          = 1'b0;
      io_buffer_full = 1'b0;
      LSB_enable     = 1'b0;
      LSB_is_write   = 1'b0;
      LSB_addr       = '0;
      LSB_data_len   = '0;
      LSB_write_data = '0;
      IF_enable      = 1'b0;
      IF_addr        = '0;
      test_reset();
      test_if_read();
      test_lsb_load();
      test_illegal_len();
      test_wrap();
      test_priority();
      test_io_stall();
      test_clear_if();
      test_clear_sw();
      test_rdy_stall();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at 100000, want finished");
      $fatal(1, "watchdog expired");
   end

endmodule
